hilo_muldiv_unit: RTL and testbench

- Iterative multiply/divide engine that owns the HI/LO register pair.
- Executes the MULT/DIV operations decoded by the control unit, which drives `start`, `multdiv` and `mod`.
- Shift-add multiply and restoring divide, one bit per cycle; `busy` is returned to stall the datapath until results commit.
- HI/LO feed the register-file writeback mux for mfhi/mflo/modulus.

---
 rtl/muldiv_pkg.sv | 17 +
 rtl/hilo_muldiv_unit_if.sv | 34 +++
 rtl/muldiv_step.sv | 38 +++
 rtl/hilo_muldiv_unit.sv | 167 ++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
// Contents: DEF_WIDTH (default operand width), OP_MULT/OP_DIV (multdiv
// encoding used by the control unit), state_e (sequencer states).
package muldiv_pkg;

  localparam int unsigned DEF_WIDTH = 32;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    COMMIT = 2'd2
  } state_e;

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Control-unit <-> multiply/divide unit bus.
// master: drives start, multdiv, mod, mfhi, a, b; receives busy, done, div0,
//         hi, lo, rd_data.
// slave:  the multiply/divide unit (mirror of master).
interface hilo_muldiv_unit_if
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);

  logic             start;
  logic             multdiv;
  logic             mod;
  logic             mfhi;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] rd_data;

  modport master (
    output start, multdiv, mod, mfhi, a, b,
    input  busy, done, div0, hi, lo, rd_data
  );

  modport slave (
    input  start, multdiv, mod, mfhi, a, b,
    output busy, done, div0, hi, lo, rd_data
  );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of the shift-add multiply / restoring divide.
// Ports: op (OP_MULT/OP_DIV), acc (2*WIDTH accumulator), operand
// (multiplicand or divisor), acc_next (accumulator after the step; for a
// divide its LSB is left clear), q_bit (quotient bit produced by a divide step).
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic               op,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next,
  output logic               q_bit
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;

  always_comb begin
    // Multiply: conditionally add multiplicand to upper half, keep carry.
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    // Divide: remainder shifted left by one, needs WIDTH+1 bits.
    rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    // Only consumed when rem_sh >= operand, so the result fits WIDTH bits.
    diff     = rem_sh[WIDTH-1:0] - operand;
    acc_next = '0;
    q_bit    = 1'b0;
    if (op == OP_MULT) begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end else begin
      q_bit    = (rem_sh >= {1'b0, operand});
      acc_next = {(q_bit ? diff : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide engine owning the HI/LO register pair.
// Ports: clk, reset (sync, active-high), bus (hilo_muldiv_unit_if.slave).
// Latency: start edge, WIDTH step edges, one commit edge; done pulses after commit.
// Optional: define MULDIV_SIGNED_EN for two's-complement operands.
module hilo_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  hilo_muldiv_unit_if.slave    bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic               op_q, op_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q;
  logic               done_q, done_d;
`ifdef MULDIV_SIGNED_EN
  logic               b_neg_q, b_neg_d;
`endif

  logic [2*WIDTH-1:0] step_acc;
  logic               step_q;
  logic [WIDTH-1:0]   a_mag, b_mag, quo, rem;
  logic [2*WIDTH-1:0] prod;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op       (op_q),
    .acc      (acc_q),
    .operand  (opnd_q),
    .acc_next (step_acc),
    .q_bit    (step_q)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    a_d     = a_q;
    op_d    = op_q;
    div0_d  = div0_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
`ifdef MULDIV_SIGNED_EN
    b_neg_d = b_neg_q;
    a_mag   = bus.a[WIDTH-1] ? -bus.a : bus.a;
    b_mag   = bus.b[WIDTH-1] ? -bus.b : bus.b;
`else
    a_mag   = bus.a;
    b_mag   = bus.b;
`endif
    prod    = acc_q;
    quo     = acc_q[WIDTH-1:0];
    rem     = acc_q[2*WIDTH-1:WIDTH];

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d   = bus.multdiv;
          a_d    = bus.a;
          div0_d = 1'b0;
          cnt_d  = '0;
`ifdef MULDIV_SIGNED_EN
          b_neg_d = bus.b[WIDTH-1];
`endif
          // Multiply: multiplier sits in the low half, shifted out LSB first.
          // Divide: dividend sits in the low half, shifted out MSB first.
          if (bus.multdiv == OP_MULT) begin
            acc_d  = {WIDTH'(0), b_mag};
            opnd_d = a_mag;
          end else begin
            acc_d  = {WIDTH'(0), a_mag};
            opnd_d = b_mag;
          end
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = step_acc | {{(2*WIDTH-1){1'b0}}, step_q};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (op_q == OP_DIV && opnd_q == '0) begin
          lo_d   = '1;
          hi_d   = a_q;
          div0_d = 1'b1;
        end else if (op_q == OP_MULT) begin
`ifdef MULDIV_SIGNED_EN
          if (a_q[WIDTH-1] ^ b_neg_q) prod = -acc_q;
`endif
          {hi_d, lo_d} = prod;
        end else begin
`ifdef MULDIV_SIGNED_EN
          if (a_q[WIDTH-1] ^ b_neg_q) quo = -acc_q[WIDTH-1:0];
          if (a_q[WIDTH-1])           rem = -acc_q[2*WIDTH-1:WIDTH];
`endif
          lo_d = quo;
          hi_d = rem;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      a_q     <= '0;
      op_q    <= OP_MULT;
      div0_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      b_neg_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      a_q     <= a_d;
      op_q    <= op_d;
      div0_q  <= div0_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= done_d;
`ifdef MULDIV_SIGNED_EN
      b_neg_q <= b_neg_d;
`endif
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.div0    = div0_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  // Writeback read port: mfhi overrides the mod select.
  assign bus.rd_data = (bus.mfhi | bus.mod) ? hi_q : lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed-vector bench for hilo_muldiv_unit with hand-computed results.
module tb_hilo_muldiv_unit;
  import muldiv_pkg::*;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hilo_muldiv_unit_if #(.WIDTH(W)) bus();

  hilo_muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errs   = 0;
  int edge_n   = 0;
  int busy_cnt = 0;
  int done_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; observe 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
    if (bus.busy) busy_cnt++;
  endtask

  // Present a start request, sampled at edge 0.
  task automatic launch(input logic md, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.multdiv = md;
    bus.a       = a;
    bus.b       = b;
    bus.start   = 1'b1;
    edge_n      = -1;
    busy_cnt    = 0;
    tick();
    bus.start   = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    while (!bus.done && edge_n < 100) tick();
    check({tag, ".latency"}, 64'(edge_n), 64'd33);
  endtask

  task automatic run_op(input string tag, input logic md, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                        input logic [W-1:0] exp_lo, input logic exp_div0);
    launch(md, a, b);
    wait_done(tag);
    check({tag, ".hi"},   64'(bus.hi),   64'(exp_hi));
    check({tag, ".lo"},   64'(bus.lo),   64'(exp_lo));
    check({tag, ".div0"}, 64'(bus.div0), 64'(exp_div0));
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.multdiv = OP_MULT;
    bus.mod     = 1'b0;
    bus.mfhi    = 1'b0;
    bus.a       = '0;
    bus.b       = '0;
    reset       = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("rst.busy", 64'(bus.busy), 64'd0);
    check("rst.done", 64'(bus.done), 64'd0);
    check("rst.div0", 64'(bus.div0), 64'd0);
    check("rst.hi",   64'(bus.hi),   64'd0);
    check("rst.lo",   64'(bus.lo),   64'd0);

    // Small multiply with busy width and single-cycle done.
    run_op("mul7x6", OP_MULT, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0);
    check("mul7x6.busy_cycles", 64'(busy_cnt), 64'd33);
    check("mul7x6.busy_at_done", 64'(bus.busy), 64'd0);
    tick();
    check("mul7x6.done_width", 64'(bus.done), 64'd0);

    run_op("mul2p32", OP_MULT, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 1'b0);

    // Divide and the writeback read port.
    run_op("div100_7", OP_DIV, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    bus.mod = 1'b1; #1;
    check("rd.mod1", 64'(bus.rd_data), 64'd2);
    bus.mod = 1'b0; #1;
    check("rd.mod0", 64'(bus.rd_data), 64'd14);
    bus.mfhi = 1'b1; #1;
    check("rd.mfhi", 64'(bus.rd_data), 64'd2);
    bus.mfhi = 1'b0;

    run_op("div3_10", OP_DIV, 32'd3, 32'd10, 32'd3, 32'd0, 1'b0);
    run_op("divmax_1", OP_DIV, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0);

    // Divide by zero, then the next start clears div0.
    run_op("div5_0", OP_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
    launch(OP_DIV, 32'd9, 32'd3);
    check("div0.cleared", 64'(bus.div0), 64'd0);
    wait_done("div9_3");
    check("div9_3.lo", 64'(bus.lo), 64'd3);
    check("div9_3.hi", 64'(bus.hi), 64'd0);

`ifdef MULDIV_SIGNED_EN
    run_op("sdiv-7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("smul-7x3", OP_MULT, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("sdivmin_-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
`else
    run_op("mulmax", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 1'b0);
    run_op("divmin_max", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
`endif

    // Start re-pulsed mid-run with new operands is ignored.
    launch(OP_MULT, 32'd7, 32'd6);
    while (edge_n < 9) tick();
    bus.multdiv = OP_DIV;
    bus.a       = 32'd100;
    bus.b       = 32'd3;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    wait_done("repulse");
    check("repulse.hi", 64'(bus.hi), 64'd0);
    check("repulse.lo", 64'(bus.lo), 64'd42);

    // Reset at edge 15 discards the operation.
    launch(OP_MULT, 32'd9, 32'd9);
    while (edge_n < 14) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst.busy", 64'(bus.busy), 64'd0);
    check("midrst.hi",   64'(bus.hi),   64'd0);
    check("midrst.lo",   64'(bus.lo),   64'd0);
    done_cnt = 0;
    repeat (40) begin
      tick();
      if (bus.done) done_cnt++;
    end
    check("midrst.no_done", 64'(done_cnt), 64'd0);

    // Start in the done cycle is accepted.
    run_op("b2b_first", OP_DIV, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    launch(OP_MULT, 32'd7, 32'd6);
    check("b2b.busy", 64'(bus.busy), 64'd1);
    check("b2b.done", 64'(bus.done), 64'd0);
    wait_done("b2b_second");
    check("b2b_second.lo", 64'(bus.lo), 64'd42);
    check("b2b_second.hi", 64'(bus.hi), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
